dpram_port_arb: RTL

- Two-requester arbiter that shares one port of the byte-addressable 32-bit dual-port RAM.
- Typical use: LSU plus debug/DMA master on the data port.
- The RAM port is always ready, returns read data one cycle after a read is accepted, and ignores response back-pressure.
- This block does round-robin request arbitration, tracks in-flight reads, routes each response to its requester, and buffers responses so requesters may stall.

---
 rtl/dpram_port_arb.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dpram_port_arb.sv
// dpram_port_arb
//   Lets two requesters (typically an LSU and a debug/DMA master) share one
//   port of a byte-addressable 32-bit dual-port RAM. Requests are arbitrated
//   round-robin. Each requester has its own response FIFO. A per-requester
//   credit count limits the reads it may have outstanding, so a returning
//   read always finds room in its FIFO.
//   The RAM port is assumed always ready, returns read data exactly one
//   cycle after accepting a read, and cannot be back-pressured.
//
// Ports
//   clk, rstf                      clock, asynchronous active-low reset
//   t_rX_valid/ready/we/addr/
//   t_rX_data/mask                 request channel from requester X
//   i_rX_valid/ready/data          read response channel to requester X
//   i_m_valid/ready/we/addr/
//   i_m_data/mask                  request channel to the RAM
//   t_m_valid/data                 read data returned by the RAM
//   err                            sticky protocol error
module dpram_port_arb #(
    parameter int  DEPTH      = 8192,
    parameter int  RESP_DEPTH = 2,
    localparam int AW         = $clog2(DEPTH) + 2
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic                 t_r0_valid,
    output logic                 t_r0_ready,
    input  logic                 t_r0_we,
    input  logic [AW-1:0]        t_r0_addr,
    input  logic [3:0][7:0]      t_r0_data,
    input  logic [3:0]           t_r0_mask,
    input  logic                 t_r1_valid,
    output logic                 t_r1_ready,
    input  logic                 t_r1_we,
    input  logic [AW-1:0]        t_r1_addr,
    input  logic [3:0][7:0]      t_r1_data,
    input  logic [3:0]           t_r1_mask,
    output logic                 i_r0_valid,
    input  logic                 i_r0_ready,
    output logic [3:0][7:0]      i_r0_data,
    output logic                 i_r1_valid,
    input  logic                 i_r1_ready,
    output logic [3:0][7:0]      i_r1_data,
    output logic                 i_m_valid,
    input  logic                 i_m_ready,
    output logic                 i_m_we,
    output logic [AW-1:0]        i_m_addr,
    output logic [3:0][7:0]      i_m_data,
    output logic [3:0]           i_m_mask,
    input  logic                 t_m_valid,
    input  logic [3:0][7:0]      t_m_data,
    output logic                 err
);

    localparam logic [1:0] CREDIT_MAX = 2'(RESP_DEPTH);

    // Requester channels gathered into arrays so both sides share one description.
    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [31:0]   req_data  [2];
    logic [3:0]    req_mask  [2];
    logic          rsp_ready [2];

    assign req_valid[0] = t_r0_valid;
    assign req_valid[1] = t_r1_valid;
    assign req_we[0]    = t_r0_we;
    assign req_we[1]    = t_r1_we;
    assign req_addr[0]  = t_r0_addr;
    assign req_addr[1]  = t_r1_addr;
    assign req_data[0]  = t_r0_data;
    assign req_data[1]  = t_r1_data;
    assign req_mask[0]  = t_r0_mask;
    assign req_mask[1]  = t_r1_mask;
    assign rsp_ready[0] = i_r0_ready;
    assign rsp_ready[1] = i_r1_ready;

    logic          last_grant_q,   last_grant_d;
    logic          in_flight_q,    in_flight_d;
    logic          in_flight_id_q, in_flight_id_d;
    logic          err_q,          err_d;
    // High until the first clock edge after reset release; a RAM response
    // to a read issued before reset may still land in that cycle.
    logic          post_rst_q,     post_rst_d;
    logic [1:0]    credit_q [2],   credit_d [2];
    logic [1:0]    cnt_q    [2],   cnt_d    [2];
    logic          wr_ptr_q [2],   wr_ptr_d [2];
    logic          rd_ptr_q [2],   rd_ptr_d [2];
    logic [31:0]   fifo_q   [2][2];
    logic [31:0]   fifo_d   [2][2];

    logic          pop  [2];
    logic          elig [2];
    logic          gnt_vld;
    logic          gnt_id;
    logic          accept;
    logic          issue_rd;

    function automatic logic ptr_inc(input logic p);
        return (RESP_DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // Arbitration. Gating eligibility with rstf keeps every request-side
    // output low for the whole reset, even while requesters hold valid high.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            pop[x]  = (cnt_q[x] != 2'd0) & rsp_ready[x];
            // A pop this cycle frees a credit, so a read may issue alongside it.
            elig[x] = rstf & req_valid[x] &
                      (req_we[x] | (credit_q[x] < CREDIT_MAX) | pop[x]);
        end
        gnt_vld  = elig[0] | elig[1];
        gnt_id   = (elig[0] & elig[1]) ? ~last_grant_q : elig[1];
        accept   = gnt_vld & i_m_ready;
        issue_rd = accept & ~req_we[gnt_id];
    end

    assign i_m_valid  = gnt_vld;
    assign i_m_we     = gnt_vld & req_we[gnt_id];
    assign i_m_addr   = gnt_vld ? req_addr[gnt_id] : '0;
    assign i_m_data   = gnt_vld ? req_data[gnt_id] : '0;
    assign i_m_mask   = gnt_vld ? req_mask[gnt_id] : '0;
    assign t_r0_ready = gnt_vld & ~gnt_id & i_m_ready;
    assign t_r1_ready = gnt_vld &  gnt_id & i_m_ready;

    assign i_r0_valid = (cnt_q[0] != 2'd0);
    assign i_r1_valid = (cnt_q[1] != 2'd0);
    assign i_r0_data  = fifo_q[0][rd_ptr_q[0]];
    assign i_r1_data  = fifo_q[1][rd_ptr_q[1]];
    assign err        = err_q;

    always_comb begin
        logic push_x;
        logic release_x;
        logic issue_x;

        last_grant_d   = accept ? gnt_id : last_grant_q;
        in_flight_d    = issue_rd;
        in_flight_id_d = issue_rd ? gnt_id : 1'b0;
        post_rst_d     = 1'b0;
        // Stray RAM data (nothing in flight) or a missing response both flag err.
        err_d          = err_q
                       | (t_m_valid & ~in_flight_q & ~post_rst_q)
                       | (in_flight_q & ~t_m_valid);
        push_x         = 1'b0;
        release_x      = 1'b0;
        issue_x        = 1'b0;

        for (int x = 0; x < 2; x++) begin
            fifo_d[x][0] = fifo_q[x][0];
            fifo_d[x][1] = fifo_q[x][1];
            wr_ptr_d[x]  = wr_ptr_q[x];
            rd_ptr_d[x]  = rd_ptr_q[x];

            push_x    = in_flight_q & t_m_valid  & (in_flight_id_q == 1'(x));
            // A lost response returns its credit so the requester cannot starve.
            release_x = in_flight_q & ~t_m_valid & (in_flight_id_q == 1'(x));
            issue_x   = issue_rd & (gnt_id == 1'(x));

            if (push_x) begin
                fifo_d[x][wr_ptr_q[x]] = t_m_data;
                wr_ptr_d[x]            = ptr_inc(wr_ptr_q[x]);
            end
            if (pop[x]) begin
                rd_ptr_d[x] = ptr_inc(rd_ptr_q[x]);
            end

            cnt_d[x]    = cnt_q[x] + {1'b0, push_x} - {1'b0, pop[x]};
            credit_d[x] = credit_q[x] + {1'b0, issue_x}
                        - {1'b0, pop[x]} - {1'b0, release_x};
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            last_grant_q   <= 1'b1;
            in_flight_q    <= 1'b0;
            in_flight_id_q <= 1'b0;
            err_q          <= 1'b0;
            post_rst_q     <= 1'b1;
            for (int x = 0; x < 2; x++) begin
                credit_q[x]  <= '0;
                cnt_q[x]     <= '0;
                wr_ptr_q[x]  <= 1'b0;
                rd_ptr_q[x]  <= 1'b0;
                fifo_q[x][0] <= '0;
                fifo_q[x][1] <= '0;
            end
        end else begin
            last_grant_q   <= last_grant_d;
            in_flight_q    <= in_flight_d;
            in_flight_id_q <= in_flight_id_d;
            err_q          <= err_d;
            post_rst_q     <= post_rst_d;
            for (int x = 0; x < 2; x++) begin
                credit_q[x]  <= credit_d[x];
                cnt_q[x]     <= cnt_d[x];
                wr_ptr_q[x]  <= wr_ptr_d[x];
                rd_ptr_q[x]  <= rd_ptr_d[x];
                fifo_q[x][0] <= fifo_d[x][0];
                fifo_q[x][1] <= fifo_d[x][1];
            end
        end
    end

endmodule
